// File: rtl/syn_fifo02.sv
// Single-clock FIFO with occupancy count, almost flags and sticky overflow/underflow.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered reads.
module syn_fifo02 #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_en,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       r_en,
   input  logic                       clr_err,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  full_q, full_d, empty_q, empty_d;
   logic                  af_q, af_d, ae_q, ae_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  wr_acc_s, rd_acc_s;

   // Next-state logic; accepts are judged against the flags registered before this edge.
   always_comb begin
      wr_acc_s = w_en & ~full_q;
      rd_acc_s = r_en & ~empty_q;

      if (wr_acc_s) wr_ptr_d = wr_ptr_q + CW'(1);
      else          wr_ptr_d = wr_ptr_q;

      if (rd_acc_s) rd_ptr_d = rd_ptr_q + CW'(1);
      else          rd_ptr_d = rd_ptr_q;

      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == CW'(0));
      af_d    = (count_d >= AF_C);
      ae_d    = (count_d <= AE_C);

      // A new error event wins over a simultaneous clear.
      if (w_en & full_q)  ovf_d = 1'b1;
      else if (clr_err)   ovf_d = 1'b0;
      else                ovf_d = ovf_q;

      if (r_en & empty_q) udf_d = 1'b1;
      else if (clr_err)   udf_d = 1'b0;
      else                udf_d = udf_q;

`ifdef SYN_FIFO_FWFT_EN
      // Head word after this edge; bypass when it is the word being written now.
      if (count_d == CW'(0))
         data_out_d = {DATA_WIDTH{1'b0}};
      else if (wr_acc_s && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0]))
         data_out_d = data_in;
      else
         data_out_d = mem_q[rd_ptr_d[AW-1:0]];
`else
      if (rd_acc_s) data_out_d = mem_q[rd_ptr_q[AW-1:0]];
      else          data_out_d = data_out_q;
`endif
   end

   // Storage array; intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
   end

   // Pointer, count, flag and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= CW'(0);
         rd_ptr_q   <= CW'(0);
         count_q    <= CW'(0);
         data_out_q <= {DATA_WIDTH{1'b0}};
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   assign data_out     = data_out_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_syn_fifo02.sv
// Directed scoreboard bench for syn_fifo02 (DEPTH=8, DATA_WIDTH=8, AF=6, AE=2).
module tb_syn_fifo02;

   logic       clk = 1'b0;
   logic       rst;
   logic       w_en, r_en, clr_err;
   logic [7:0] data_in, data_out;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] count;

   syn_fifo02 #(.DEPTH(8), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_pass = 0;
   int         n_fail = 0;
   logic [7:0] sb_q[$];
   logic [7:0] m_dout = 8'h00;
   logic       m_ovf  = 1'b0;
   logic       m_udf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [9:0] obs, exp;
      int         n;
      n   = sb_q.size();
      obs = {count, full, empty, almost_full, almost_empty, overflow, underflow};
      exp = {4'(n), (n == 8), (n == 0), (n >= 6), (n <= 2), m_ovf, m_udf};
      check({tag, "_status"}, 32'(obs), 32'(exp));
      check({tag, "_dout"}, 32'(data_out), 32'(m_dout));
   endtask

   // One clock cycle: drive inputs, predict from pre-edge state, compare after the edge.
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic clr, input string tag);
      logic wa, ra, was_full, was_empty;
      logic [7:0] popped;
      w_en = w; data_in = d; r_en = r; clr_err = clr;
      was_full  = (sb_q.size() == 8);
      was_empty = (sb_q.size() == 0);
      wa = w && !was_full;
      ra = r && !was_empty;
      popped = 8'h00;
      @(posedge clk); #1;
      if (ra) popped = sb_q.pop_front();
      if (wa) sb_q.push_back(d);
      if (w && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (r && was_empty) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
`ifdef SYN_FIFO_FWFT_EN
      m_dout = (sb_q.size() != 0) ? sb_q[0] : 8'h00;
`else
      if (ra) m_dout = popped;
`endif
      w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // Fill 0x01..0x08 then overflow attempt
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      step(1'b1, 8'hFF, 1'b0, 1'b0, "overflow_wr");

      // Drain in order, then underflow with data_out held
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      step(1'b0, 8'h00, 1'b1, 1'b0, "underflow_rd");
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr_both");

      // Write 5 / read 5 four times to wrap pointers
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + k * 5 + i), 1'b0, 1'b0, "wrap_wr");
         for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_rd");
      end

      // Simultaneous read/write at count 4, then at full and at empty
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre4");
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, "both_mid");
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "to_full");
      step(1'b1, 8'hA5, 1'b1, 1'b0, "both_full");
      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "to_empty");
      step(1'b1, 8'h5A, 1'b1, 1'b0, "both_empty");
      step(1'b0, 8'h00, 1'b1, 1'b0, "last_rd");

      // Clear vs set priority on overflow
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, "refill");
      step(1'b1, 8'hEE, 1'b0, 1'b0, "ovf_set");
      step(1'b1, 8'hEE, 1'b0, 1'b1, "clr_vs_set");
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr_alone");

      // Asynchronous reset mid-cycle at count 5
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "to5");
      #1;
      rst = 1'b1;
      #1;
      sb_q.delete();
      m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
      check_all("async_rst");
      #1;
      rst = 1'b0;
      step(1'b1, 8'h99, 1'b0, 1'b0, "first_wr_after_rst");
      step(1'b0, 8'h00, 1'b1, 1'b0, "first_rd_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/syn_fifo02.md
SYN_FIFO02 -- requirements
Module: syn_fifo02

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of storage entries; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per word.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in words.
REQ-005 SHALL have ports: clk  in  1  rising-edge clock (the only clock); one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: w_en  in  1  write request; data_in  in  DATA_WIDTH  write data.
REQ-008 SHALL have ports: r_en  in  1  read request; data_out  out  DATA_WIDTH  read data.
REQ-009 SHALL have ports: full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-010 SHALL have ports: count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have ports: overflow, underflow  out  1  sticky error flags; clr_err  in  1  synchronous clear of both.

Function
REQ-012 SHALL accept a write when w_en=1 and full=0: store data_in at write pointer, advance pointer modulo DEPTH.
REQ-013 SHALL accept a read when r_en=1 and empty=0: advance read pointer modulo DEPTH.
REQ-014 SHALL use all DEPTH entries: pointers carry one extra wrap bit; full = count==DEPTH, empty = count==0.
REQ-015 SHALL update count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-016 SHALL evaluate accept conditions against flags registered before the edge: when full with w_en=r_en=1, only the read is accepted; when empty with both, only the write is accepted.
REQ-017 SHALL drive almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL), all flags derived from registered state, no combinational path from w_en/r_en.
REQ-018 SHALL set overflow on any cycle with w_en=1 and full=1; underflow on r_en=1 and empty=1; both hold until clr_err or reset.
REQ-019 SHALL give set priority over clr_err when both occur in the same cycle.
REQ-020 SHALL hold data_out unchanged on cycles with no accepted read (standard mode).
REQ-021 SHALL preserve data order across pointer wrap-around with no lost or duplicated words.

Reset
REQ-022 SHALL on rst=1, asynchronously: pointers=0, count=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-023 SHALL discard all contents on reset asserted mid-operation; storage array is not reset.
REQ-024 SHALL accept a first write on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL support macro SYN_FIFO_FWFT_EN selecting first-word-fall-through read mode.
REQ-026 SHALL without SYN_FIFO_FWFT_EN: data_out = head word registered on the edge that accepts the read, 1-cycle read latency.
REQ-027 SHALL with SYN_FIFO_FWFT_EN: data_out presents head word whenever empty=0 (0 latency); accepted read pops it and next word appears same cycle after the edge; data_out = 0 while empty.
REQ-028 SHALL keep flags, count and error behaviour identical in both modes.

Verification (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-029 SHALL cover: reset, write 0x01..0x08 -> count 8, full=1, almost_full=1 from 6th write; 9th write 0xFF -> dropped, overflow=1.
REQ-030 SHALL cover: from full, 8 reads -> data_out 0x01..0x08 in order (1-cycle lag standard / immediate FWFT), empty=1; extra read -> underflow=1, data_out held.
REQ-031 SHALL cover: write 5, read 5, repeated 4 times (pointer wrap) -> all 20 words returned in order, count returns to 0.
REQ-032 SHALL cover: count=4, w_en=r_en=1 for 10 cycles -> count stays 4, order preserved; at full with both -> read only, count 7; at empty with both -> write only, count 1.
REQ-033 SHALL cover: overflow=1 then clr_err=1 with w_en=1 at full same cycle -> overflow stays 1; clr_err alone next cycle -> overflow=0.
REQ-034 SHALL cover: rst pulsed mid-cycle with count=5 -> immediately count=0, empty=1, data_out=0 without waiting for clk edge.
